// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: response owner encoding and the
// registered response descriptor.
package sram_arb_pkg;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } resp_t;

   localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive cycles a pending fetch loses
// arbitration and raises force_i once the limit is reached.
module sram_arb_starve_ctr
   import sram_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic i_gnt,
   output logic force_i
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_LIMIT[STARVE_CNT_W-1:0];

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (i_req && !i_gnt) begin
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_i = (cnt_q >= LIMIT);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between the fetch port and the
// load/store port; data has priority unless a starving fetch is forced.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned NUM_BYTES    = DATA_WIDTH / 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [NUM_BYTES-1:0]  d_be,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_sel,
   output logic                  mem_we,
   output logic [NUM_BYTES-1:0]  mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   input  logic                  mem_ack
);

   logic                  force_i;
   resp_t                 resp_q;
   resp_t                 resp_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] din_q;
   logic [DATA_WIDTH-1:0] din_d;
   logic                  chk_en_q;

   sram_arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (i_req),
      .i_gnt   (i_gnt),
      .force_i (force_i)
   );

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      d_gnt = rst_n && d_req && !force_i;
      i_gnt = rst_n && i_req && !d_gnt;
   end

   // Address and write data hold their last driven value when idle.
   always_comb begin
      addr_d  = addr_q;
      din_d   = din_q;
      mem_sel = 1'b0;
      mem_we  = 1'b0;
      mem_be  = '0;
      if (d_gnt) begin
         addr_d  = d_addr;
         din_d   = d_wdata;
         mem_sel = 1'b1;
         mem_we  = d_we;
         mem_be  = d_we ? d_be : '0;
      end else if (i_gnt) begin
         addr_d  = i_addr;
         mem_sel = 1'b1;
      end
   end

   assign mem_addr = addr_d;
   assign mem_din  = din_d;

   always_comb begin
      resp_d.valid = d_gnt || i_gnt;
      resp_d.owner = d_gnt ? OWNER_DATA : OWNER_FETCH;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q.valid <= 1'b0;
         resp_q.owner <= OWNER_FETCH;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         resp_q <= resp_d;
         addr_q <= addr_d;
         din_q  <= din_d;
      end
   end

   assign i_rvalid = resp_q.valid && (resp_q.owner == OWNER_FETCH);
   assign d_rvalid = resp_q.valid && (resp_q.owner == OWNER_DATA);
   assign i_rdata  = mem_dout;
   assign d_rdata  = mem_dout;

   // The SRAM ack register is not reset, so its echo is only trusted once a
   // full cycle has passed since reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_en_q <= 1'b0;
      end else begin
         chk_en_q <= 1'b1;
         if (chk_en_q) begin
            assert (mem_ack == resp_q.valid);
         end
      end
   end

endmodule
